// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit level. Both stages clear on rst.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/signal_holder.sv
// Pulse stretcher: signal_out stays high HOLD_TIME cycles after the last high sample of signal_in.
// Define SIGNAL_HOLDER_SYNC_EN to put a two-flop synchronizer in front of the hold logic.
module signal_holder #(
    parameter int unsigned HOLD_TIME = 1200000,
    parameter int unsigned CNT_W     = $clog2(HOLD_TIME + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic signal_in,
    output logic signal_out
);

    // Reject illegal configurations at elaboration time.
    if (HOLD_TIME < 1 || HOLD_TIME > 32'd16777215) begin : g_bad_hold
        $error("signal_holder: HOLD_TIME %0d outside 1..2^24-1", HOLD_TIME);
    end
    if (CNT_W != $clog2(HOLD_TIME + 1)) begin : g_bad_cnt_w
        $error("signal_holder: CNT_W is derived from HOLD_TIME and must not be overridden");
    end

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_TIME - 1);

    logic             in_s;
    logic [CNT_W-1:0] cnt;
    logic             out_q;

`ifdef SIGNAL_HOLDER_SYNC_EN
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (signal_in),
        .q   (in_s)
    );
`else
    assign in_s = signal_in;
`endif

    // Load on every high sample; otherwise count down to zero and then drop the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            out_q <= 1'b0;
        end else if (in_s) begin
            cnt   <= LOAD_VAL;
            out_q <= 1'b1;
        end else if (cnt != '0) begin
            cnt   <= cnt - CNT_W'(1);
            out_q <= 1'b1;
        end else begin
            cnt   <= '0;
            out_q <= 1'b0;
        end
    end

    assign signal_out = out_q;

endmodule

// File: tb/tb_signal_holder.sv
// Directed self-checking bench for signal_holder (HOLD_TIME=5 and HOLD_TIME=1 instances).
module tb_signal_holder;

    typedef struct packed {
        logic rst;
        logic in;
        logic exp5;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signal_in = 1'b0;
    logic out5;
    logic out1;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    signal_holder #(.HOLD_TIME(5)) dut5 (
        .clk        (clk),
        .rst        (rst),
        .signal_in  (signal_in),
        .signal_out (out5)
    );

    signal_holder #(.HOLD_TIME(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .signal_in  (signal_in),
        .signal_out (out1)
    );

    task automatic add(input logic r, input logic i, input logic e, input int n);
        vec_t v;
        v.rst  = r;
        v.in   = i;
        v.exp5 = e;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic i);
        @(negedge clk);
        rst       = r;
        signal_in = i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with input high: output held low, rises on first edge after reset.
        add(1, 1, 0, 3);
        add(0, 1, 1, 1);
        add(0, 0, 1, 4);
        add(0, 0, 0, 2);
        // Single-cycle pulse: 5 cycles high.
        add(0, 1, 1, 1);
        add(0, 0, 1, 4);
        add(0, 0, 0, 2);
        // 10-cycle level: 14 cycles high.
        add(0, 1, 1, 10);
        add(0, 0, 1, 4);
        add(0, 0, 0, 1);
        // Retrigger at 0 and 4: continuous high 0..8.
        add(0, 1, 1, 1);
        add(0, 0, 1, 3);
        add(0, 1, 1, 1);
        add(0, 0, 1, 4);
        add(0, 0, 0, 1);
        // Pulses at 0 and 6: one low cycle between holds.
        add(0, 1, 1, 1);
        add(0, 0, 1, 4);
        add(0, 0, 0, 1);
        add(0, 1, 1, 1);
        add(0, 0, 1, 4);
        add(0, 0, 0, 1);
        // Reset mid-hold, then a fresh full hold.
        add(0, 1, 1, 1);
        add(0, 0, 1, 1);
        add(1, 0, 0, 1);
        add(0, 0, 0, 1);
        add(0, 1, 1, 1);
        add(0, 0, 1, 4);
        add(0, 0, 0, 1);
        // Reset wins over a high input.
        add(0, 1, 1, 1);
        add(1, 1, 0, 1);
        add(0, 0, 0, 1);
        // Gap of exactly HOLD_TIME merges with no glitch.
        add(0, 1, 1, 1);
        add(0, 0, 1, 4);
        add(0, 1, 1, 1);
        add(0, 0, 1, 4);
        add(0, 0, 0, 2);

`ifndef SIGNAL_HOLDER_SYNC_EN
        foreach (vecs[n]) begin
            step(vecs[n].rst, vecs[n].in);
            check("hold5", n, out5, vecs[n].exp5);
            check("hold1", n, out1, vecs[n].in & ~vecs[n].rst);
        end
`else
        // Synchronized input: pulse at edge 0 gives output high edges 2..6.
        step(1, 0);
        step(1, 0);
        for (int k = 0; k < 10; k++) begin
            step(0, k == 0);
            check("sync_hold5", k, out5, (k >= 2 && k <= 6));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/signal_holder.md
Name: signal_holder

Overview:
- Pulse stretcher / hold-off timer for a single-bit event.
- Any cycle with signal_in high forces signal_out high; signal_out stays high for HOLD_TIME clock cycles after the last cycle in which signal_in was sampled high.
- Used by the game controller to stretch short per-direction collision detections, so a movement FSM on a slower clock always sees them.
- One instance per direction bit.

Parameters:
- HOLD_TIME, default 1200000: number of clk cycles signal_out stays asserted after the last sampled-high input. Legal range is 1 to 2^24-1; out-of-range values are an elaboration error.
- CNT_W, default $clog2(HOLD_TIME+1): counter width. Derived; must not be overridden.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- signal_in  input  1  level or pulse to be held; treated as synchronous to clk unless the optional feature is enabled.
- signal_out  output  1  held/stretched version of signal_in; driven directly from a register, with no combinational path from signal_in.

Behaviour:
- Internal state: counter cnt[CNT_W-1:0] and register out_q. signal_out = out_q.
- Reset, when rst is high at a rising edge:
  - cnt <= 0, out_q <= 0.
  - rst has priority over signal_in.
  - Reset mid-hold ends the hold immediately: signal_out is 0 from the next cycle.
- Rising edge with rst=0 and sampled in=1 (load or retrigger):
  - cnt <= HOLD_TIME-1, out_q <= 1.
  - A retrigger during a hold reloads the counter, so the hold is measured from the latest high sample. Holds are not accumulated.
- Rising edge with rst=0, sampled in=0, and cnt != 0: cnt <= cnt-1, out_q <= 1.
- Rising edge with rst=0, sampled in=0, and cnt == 0: cnt stays 0, out_q <= 0.
- Latency: signal_out rises one clk edge after signal_in is sampled high.
- Pulse length:
  - A single-cycle input pulse gives exactly HOLD_TIME cycles of signal_out high.
  - An input held high for N consecutive cycles gives N+HOLD_TIME-1 cycles of signal_out high.
  - Inputs whose gap is at most HOLD_TIME cycles merge into one continuous output pulse with no low glitch.
- HOLD_TIME=1: the block degenerates to a single D flip-flop (signal_out = signal_in delayed one cycle).
- Counter arithmetic:
  - Unsigned; decrement only when cnt is nonzero, so no wrap-around.
  - cnt never exceeds HOLD_TIME-1.
- No state machine beyond the two implicit states: IDLE (cnt==0 and out_q==0) and HOLDING (out_q==1).
- Power-up before the first reset is unspecified. The integrating design must assert rst at least once.

Optional Feature:
- Macro SIGNAL_HOLDER_SYNC_EN.
- Defined:
  - signal_in passes through a two-flop synchronizer, both flops reset to 0 by rst, before the hold logic.
  - Total input-to-output latency becomes 3 clk edges.
  - Pulse lengths are unchanged.
  - Asynchronous inputs are then permitted.
- Undefined:
  - signal_in feeds the hold logic directly, with latency 1 as stated above.
  - signal_in must be synchronous to clk.

Decomposition:
- No shared package is needed. The only constant is HOLD_TIME, which is a per-instance parameter, and CNT_W is computed locally.
- One natural sub-module: sync_2ff (2-flop synchronizer, ports clk, rst, d, q). It is instantiated only under SIGNAL_HOLDER_SYNC_EN.
- Counter and output register stay in signal_holder.

Test Plan (HOLD_TIME=5 unless stated, macro undefined):
- Reset: rst=1 for 3 cycles with signal_in=1 -> signal_out=0 throughout; first edge after rst falls -> signal_out=1.
- Single pulse: signal_in=1 for 1 cycle at edge k -> signal_out=1 at edges k..k+4 (5 cycles), 0 at k+5 and after.
- Long level: signal_in=1 for 10 cycles -> signal_out high for 14 consecutive cycles, then 0.
- Retrigger: pulses at edges 0 and 4 -> signal_out continuously high edges 0..8, falls at edge 9. Pulses at 0 and 6 -> high 0..4, low at 5, high 6..10.
- Reset mid-hold: pulse at edge 0, rst=1 at edge 2 -> signal_out=0 from edge 2. A later pulse restarts a full 5-cycle hold.
- Edge parameter and macro: HOLD_TIME=1 -> signal_out equals signal_in delayed 1 cycle. With SIGNAL_HOLDER_SYNC_EN defined, HOLD_TIME=5, pulse at edge 0 -> signal_out high edges 2..6.
